// File: rtl/gnr_pkg.sv
// Shared definitions for the gene-regulatory-network attractor sequencer.
package gnr_pkg;

  localparam int GNR_N_NODES = 188;
  localparam int GNR_CNT_W   = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_PERIOD = 3'd3,
    S_DONE   = 3'd4
  } gnr_state_t;

endpackage

// File: rtl/gnr_attractor_ctrl.sv
// Floyd cycle-detection sequencer: loads a seed, runs tortoise/hare until they meet, then measures period.
// Step strobes are combinational so a meet or budget limit stops them in the same cycle (no overshoot).
module gnr_attractor_ctrl
  import gnr_pkg::*;
#(
  parameter int N_NODES   = GNR_N_NODES,
  parameter int CNT_W     = GNR_CNT_W,
  parameter int MAX_STEPS = 65535
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [N_NODES-1:0] i_seed,
  input  logic [N_NODES-1:0] i_s0_vec,
  input  logic [N_NODES-1:0] i_s1_vec,
  output logic [N_NODES-1:0] o_init_state,
  output logic               o_reset_nos,
  output logic               o_start_s0,
  output logic               o_start_s1,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_timeout,
  output logic [CNT_W-1:0]   o_meet_steps,
  output logic [CNT_W-1:0]   o_period,
  output logic [N_NODES-1:0] o_attractor
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] LP_TWO = CNT_W'(2);

  gnr_state_t         r_state;
  logic [CNT_W-1:0]   r_steps;
  logic [CNT_W-1:0]   r_lam;
  logic [N_NODES-1:0] r_init_state;
  logic               r_timeout;
  logic [CNT_W-1:0]   r_meet_steps;
  logic [CNT_W-1:0]   r_period;
  logic [N_NODES-1:0] r_attractor;

  logic w_eq;
  logic w_hit;
  logic w_steps_max;
  logic w_lam_max;
  logic w_per_hit;

  assign w_eq        = (i_s0_vec == i_s1_vec);
  // Steps 0 and 1 always compare equal (tortoise advances on the first strobe), so they are excluded.
  assign w_hit       = w_eq && (r_steps >= LP_TWO);
  assign w_steps_max = (r_steps == LP_MAX);
  assign w_lam_max   = (r_lam == LP_MAX);
  assign w_per_hit   = w_eq && (r_lam != '0);

  assign o_reset_nos = (r_state == S_LOAD);
  assign o_start_s0  = (r_state == S_RUN) && !w_hit && !w_steps_max;
  assign o_start_s1  = ((r_state == S_RUN) && !w_hit && !w_steps_max) ||
                       ((r_state == S_PERIOD) && !w_per_hit && !w_lam_max);

  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE);
  assign o_init_state = r_init_state;
  assign o_timeout    = r_timeout;
  assign o_meet_steps = r_meet_steps;
  assign o_period     = r_period;
  assign o_attractor  = r_attractor;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_steps      <= '0;
      r_lam        <= '0;
      r_init_state <= '0;
      r_timeout    <= 1'b0;
      r_meet_steps <= '0;
      r_period     <= '0;
      r_attractor  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_init_state <= i_seed;
            r_timeout    <= 1'b0;
            r_meet_steps <= '0;
            r_period     <= '0;
            r_attractor  <= '0;
            r_state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_steps <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_hit) begin
            r_meet_steps <= r_steps;
            r_attractor  <= i_s0_vec;
            r_lam        <= '0;
            r_state      <= S_PERIOD;
          end else if (w_steps_max) begin
            r_timeout <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_steps <= r_steps + 1'b1;
          end
        end
        S_PERIOD: begin
          // Tortoise is frozen at the meet point; hare walks until it returns to it.
          if (w_per_hit) begin
            r_period <= r_lam;
            r_state  <= S_DONE;
          end else if (w_lam_max) begin
            r_timeout <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_lam <= r_lam + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Scoreboard bench for gnr_attractor_ctrl with behavioural 3-node networks (fixed point or rotate ring).
module tb_gnr_attractor_ctrl;

  typedef struct {
    logic [15:0] meet;
    logic [15:0] per;
    logic [2:0]  attr;
    logic        tmo;
    int          start_cyc;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t qa[$];
  exp_t qb[$];

  // instance A: unlimited budget; instance B: MAX_STEPS = 4
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [2:0]  seed_a = '0, seed_b = '0;
  logic [2:0]  s0a, s1a, s0b, s1b;
  logic        pa, pb;
  bit          ring_a = 1'b0, ring_b = 1'b0;
  logic [2:0]  init_a, init_b, attr_a, attr_b;
  logic        rn_a, rn_b, ss0_a, ss0_b, ss1_a, ss1_b;
  logic        busy_a, busy_b, done_a, done_b, tmo_a, tmo_b;
  logic [15:0] meet_a, meet_b, per_a, per_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gnr_attractor_ctrl #(.N_NODES(3), .CNT_W(16), .MAX_STEPS(65535)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_seed(seed_a),
    .i_s0_vec(s0a), .i_s1_vec(s1a), .o_init_state(init_a), .o_reset_nos(rn_a),
    .o_start_s0(ss0_a), .o_start_s1(ss1_a), .o_busy(busy_a), .o_done(done_a),
    .o_timeout(tmo_a), .o_meet_steps(meet_a), .o_period(per_a), .o_attractor(attr_a)
  );

  gnr_attractor_ctrl #(.N_NODES(3), .CNT_W(16), .MAX_STEPS(4)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_seed(seed_b),
    .i_s0_vec(s0b), .i_s1_vec(s1b), .o_init_state(init_b), .o_reset_nos(rn_b),
    .o_start_s0(ss0_b), .o_start_s1(ss1_b), .o_busy(busy_b), .o_done(done_b),
    .o_timeout(tmo_b), .o_meet_steps(meet_b), .o_period(per_b), .o_attractor(attr_b)
  );

  function automatic logic [2:0] nxt(input logic [2:0] x, input bit ring);
    return ring ? {x[1:0], x[2]} : x;
  endfunction

  // Node array models: s1 steps per strobe, s0 steps on every other strobe via pass.
  always @(posedge clk) begin
    if (rst) begin
      s0a <= '0; s1a <= '0; pa <= 1'b0;
    end else if (rn_a) begin
      s0a <= init_a; s1a <= init_a; pa <= 1'b1;
    end else begin
      if (ss1_a) s1a <= nxt(s1a, ring_a);
      if (ss0_a) begin
        if (pa) s0a <= nxt(s0a, ring_a);
        pa <= ~pa;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      s0b <= '0; s1b <= '0; pb <= 1'b0;
    end else if (rn_b) begin
      s0b <= init_b; s1b <= init_b; pb <= 1'b1;
    end else begin
      if (ss1_b) s1b <= nxt(s1b, ring_b);
      if (ss0_b) begin
        if (pb) s0b <= nxt(s0b, ring_b);
        pb <= ~pb;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop an expectation whenever a DUT reports done.
  always @(negedge clk) begin
    if (!rst && done_a) begin
      chk("a_done_expected", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) begin
        exp_t e;
        e = qa.pop_front();
        chk("a_meet_steps", 32'(meet_a), 32'(e.meet));
        chk("a_period", 32'(per_a), 32'(e.per));
        chk("a_attractor", 32'(attr_a), 32'(e.attr));
        chk("a_timeout", 32'(tmo_a), 32'(e.tmo));
        chk("a_latency", 32'(cyc - e.start_cyc), 32'(e.lat));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done_b) begin
      chk("b_done_expected", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) begin
        exp_t e;
        e = qb.pop_front();
        chk("b_meet_steps", 32'(meet_b), 32'(e.meet));
        chk("b_period", 32'(per_b), 32'(e.per));
        chk("b_attractor", 32'(attr_b), 32'(e.attr));
        chk("b_timeout", 32'(tmo_b), 32'(e.tmo));
        chk("b_latency", 32'(cyc - e.start_cyc), 32'(e.lat));
      end
    end
  end

  task automatic go(input bit inst, input logic [2:0] seed, input logic [15:0] meet,
                    input logic [15:0] per, input logic [2:0] attr, input logic tmo, input int lat);
    exp_t e;
    e.meet = meet; e.per = per; e.attr = attr; e.tmo = tmo;
    e.start_cyc = cyc; e.lat = lat;
    if (inst) begin
      seed_b = seed; start_b = 1'b1; qb.push_back(e);
    end else begin
      seed_a = seed; start_a = 1'b1; qa.push_back(e);
    end
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic recover();
    rst = 1'b1;
    qa.delete();
    qb.delete();
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input bit inst);
    int n = 0;
    while ((inst ? busy_b : busy_a) && n < 300) begin
      tick();
      n++;
    end
    chk(inst ? "b_wait_idle" : "a_wait_idle", 32'(inst ? busy_b : busy_a), 32'd0);
    if (inst ? busy_b : busy_a) recover();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual running required finished");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_strobes", 32'({rn_a, ss0_a, ss1_a}), 32'd0);
    chk("rst_timeout", 32'(tmo_a), 32'd0);
    chk("rst_counters", 32'({meet_a, per_a}), 32'd0);
    chk("rst_vectors", 32'({init_a, attr_a}), 32'd0);
    rst = 1'b0;
    tick();

    // Fixed point, seed 101
    ring_a = 1'b0;
    go(1'b0, 3'b101, 16'd2, 16'd1, 3'b101, 1'b0, 7);
    chk("fix_busy_c1", 32'(busy_a), 32'd1);
    chk("fix_reset_nos_c1", 32'(rn_a), 32'd1);
    chk("fix_init_state", 32'(init_a), 32'b101);
    wait_idle(1'b0);

    // Rotate ring, two seeds
    ring_a = 1'b1;
    go(1'b0, 3'b001, 16'd6, 16'd3, 3'b001, 1'b0, 13);
    wait_idle(1'b0);
    go(1'b0, 3'b110, 16'd6, 16'd3, 3'b110, 1'b0, 13);
    wait_idle(1'b0);

    // start held high in cycles 2..8 of a run is ignored
    go(1'b0, 3'b001, 16'd6, 16'd3, 3'b001, 1'b0, 13);
    tick();
    start_a = 1'b1;
    repeat (7) tick();
    start_a = 1'b0;
    wait_idle(1'b0);

    // Budget of 4 steps on the ring, then back-to-back fixed-point run
    ring_b = 1'b1;
    go(1'b1, 3'b001, 16'd0, 16'd0, 3'b000, 1'b1, 7);
    repeat (4) tick();
    chk("tmo_s1_at_step3", 32'(ss1_b), 32'd1);
    tick();
    chk("tmo_strobes_at_step4", 32'({ss0_b, ss1_b}), 32'd0);
    tick();
    chk("tmo_done_c7", 32'(done_b), 32'd1);
    chk("tmo_flag_c7", 32'(tmo_b), 32'd1);
    tick();
    ring_b = 1'b0;
    go(1'b1, 3'b011, 16'd2, 16'd1, 3'b011, 1'b0, 7);
    chk("b2b_accepted", 32'(busy_b), 32'd1);
    chk("b2b_timeout_cleared", 32'(tmo_b), 32'd0);
    wait_idle(1'b1);

    // Reset in the middle of PERIOD (ring, meet at 6: PERIOD spans cycles 9..12)
    ring_a = 1'b1;
    go(1'b0, 3'b001, 16'd6, 16'd3, 3'b001, 1'b0, 13);
    repeat (9) tick();
    chk("mid_period_s0_frozen", 32'(ss0_a), 32'd0);
    chk("mid_period_s1_on", 32'(ss1_a), 32'd1);
    chk("mid_period_meet", 32'(meet_a), 32'd6);
    qa.delete();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_strobes", 32'({rn_a, ss0_a, ss1_a}), 32'd0);
    chk("mid_rst_regs", 32'({meet_a, init_a, attr_a}), 32'd0);
    tick(); tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("post_rst_idle", 32'(busy_a), 32'd0);
    ring_a = 1'b0;
    go(1'b0, 3'b110, 16'd2, 16'd1, 3'b110, 1'b0, 7);
    wait_idle(1'b0);

    tick(); tick();
    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
